// File: rtl/armleocpu_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : armleocpu_regfile_pkg
// Purpose  : Shared constants and FSM encoding for the register file
//            read sequencer / write front-end.
// Revision : 1.0 - initial release
// ============================================================================
package armleocpu_regfile_pkg;

  localparam int c_DEFAULT_ELEMENTS_W = 5;
  localparam int c_DEFAULT_WIDTH      = 32;
  localparam int c_ZERO_ADDR          = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD2   = 2'd1,
    CAP2  = 2'd2,
    CLEAR = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/armleocpu_regfile_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : armleocpu_regfile_ctrl_if
// Purpose  : Read-request / response / write bundle between decode-writeback
//            (master) and the register file controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface armleocpu_regfile_ctrl_if
  import armleocpu_regfile_pkg::*;
#(
  parameter int ELEMENTS_W = c_DEFAULT_ELEMENTS_W,
  parameter int WIDTH      = c_DEFAULT_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ELEMENTS_W-1:0] req_rs1;
  logic [ELEMENTS_W-1:0] req_rs2;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_rs1_data;
  logic [WIDTH-1:0]      rsp_rs2_data;
  logic                  wr_en;
  logic [ELEMENTS_W-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic                  busy;

  modport master (
    output req_valid, req_rs1, req_rs2, wr_en, wr_addr, wr_data,
    input  req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data, busy
  );

  modport slave (
    input  req_valid, req_rs1, req_rs2, wr_en, wr_addr, wr_data,
    output req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data, busy
  );

endinterface
`default_nettype wire

// File: rtl/armleocpu_regfile_one_lane.sv
`default_nettype none
// ============================================================================
// Module   : armleocpu_regfile_one_lane
// Purpose  : Register storage lane, one synchronous read port and one write
//            port. A same-cycle read/write to one entry returns the old value.
// Revision : 1.0 - initial release
// ============================================================================
module armleocpu_regfile_one_lane #(
  parameter int ELEMENTS_W = 5,
  parameter int WIDTH      = 32
) (
  input  wire logic                  clk,
  input  wire logic                  rd_en,
  input  wire logic [ELEMENTS_W-1:0] rd_addr,
  output logic      [WIDTH-1:0]      rd_data,
  input  wire logic                  wr_en,
  input  wire logic [ELEMENTS_W-1:0] wr_addr,
  input  wire logic [WIDTH-1:0]      wr_data
);

  logic [WIDTH-1:0] r_mem [0:(1<<ELEMENTS_W)-1];

  // Registered read; sees the contents before any write on the same edge.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= r_mem[rd_addr];
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/armleocpu_regfile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : armleocpu_regfile_ctrl
// Purpose  : Serialises a two-operand read into two lane reads, forwards
//            writes landing while the request is in flight, hardwires x0.
//            Optional macro ARMLEOCPU_REGFILE_CLEAR_EN zero-fills the lane
//            after reset before accepting requests.
// Revision : 1.0 - initial release
// ============================================================================
module armleocpu_regfile_ctrl
  import armleocpu_regfile_pkg::*;
#(
  parameter int ELEMENTS_W = c_DEFAULT_ELEMENTS_W,
  parameter int WIDTH      = c_DEFAULT_WIDTH
) (
  input  wire logic               clk,
  input  wire logic               rst,
  armleocpu_regfile_ctrl_if.slave bus
);

  localparam logic [ELEMENTS_W-1:0] c_ZERO = ELEMENTS_W'(c_ZERO_ADDR);

  state_t                r_state;
  state_t                w_state_next;
  logic [ELEMENTS_W-1:0] r_rs1;
  logic [ELEMENTS_W-1:0] r_rs2;
  logic                  r_fwd_hit;
  logic [WIDTH-1:0]      r_fwd_data;
  logic [WIDTH-1:0]      r_op1;
  logic [WIDTH-1:0]      r_rsp1;
  logic [WIDTH-1:0]      r_rsp2;
  logic                  r_rsp_valid;

  logic                  w_wr_ext;
  logic                  w_rd_en;
  logic [ELEMENTS_W-1:0] w_rd_addr;
  logic [WIDTH-1:0]      w_rd_data;
  logic                  w_lane_we;
  logic [ELEMENTS_W-1:0] w_lane_waddr;
  logic [WIDTH-1:0]      w_lane_wdata;

`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
  logic [ELEMENTS_W-1:0] r_clr_cnt;
  logic                  w_clr_step;
`endif

  // Writes to x0 are discarded before they reach the lane.
  assign w_wr_ext = bus.wr_en && (bus.wr_addr != c_ZERO);

  // True when the write presented this cycle targets addr.
  function automatic logic wr_hits(
    input logic [ELEMENTS_W-1:0] addr,
    input logic                  wen,
    input logic [ELEMENTS_W-1:0] waddr
  );
    return wen && (waddr == addr) && (addr != c_ZERO);
  endfunction

  // Operand value after folding in this cycle's write; x0 always reads zero.
  function automatic logic [WIDTH-1:0] fwd_operand(
    input logic [ELEMENTS_W-1:0] addr,
    input logic [WIDTH-1:0]      base,
    input logic                  wen,
    input logic [ELEMENTS_W-1:0] waddr,
    input logic [WIDTH-1:0]      wdata
  );
    if (addr == c_ZERO) begin
      return '0;
    end
    if (wr_hits(addr, wen, waddr)) begin
      return wdata;
    end
    return base;
  endfunction

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
      r_state <= CLEAR;
`else
      r_state <= IDLE;
`endif
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and lane port muxing; external writes own the write port
  // except for clear-fill cycles.
  always_comb begin
    w_state_next = r_state;
    w_rd_en      = 1'b0;
    w_rd_addr    = r_rs2;
    w_lane_we    = w_wr_ext;
    w_lane_waddr = bus.wr_addr;
    w_lane_wdata = bus.wr_data;
`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
    w_clr_step   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_rd_en      = 1'b1;
          w_rd_addr    = bus.req_rs1;
          w_state_next = RD2;
        end
      end
      RD2: begin
        w_rd_en      = 1'b1;
        w_rd_addr    = r_rs2;
        w_state_next = CAP2;
      end
      CAP2: begin
        w_state_next = IDLE;
      end
`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
      CLEAR: begin
        if (!w_wr_ext) begin
          w_lane_we    = 1'b1;
          w_lane_waddr = r_clr_cnt;
          w_lane_wdata = '0;
          w_clr_step   = 1'b1;
          if (r_clr_cnt == {ELEMENTS_W{1'b1}}) begin
            w_state_next = IDLE;
          end
        end
      end
`endif
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
  // Clear-fill address; holds while an external write owns the lane.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clr_cnt <= '0;
    end else if (w_clr_step) begin
      r_clr_cnt <= r_clr_cnt + ELEMENTS_W'(1);
    end
  end
`endif

  // Operand capture with forwarding. r_fwd_* remembers a write that hit the
  // address being read on the same edge, since the lane returns stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_fwd_hit   <= 1'b0;
      r_fwd_data  <= '0;
      r_op1       <= '0;
      r_rsp1      <= '0;
      r_rsp2      <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_rs1      <= bus.req_rs1;
            r_rs2      <= bus.req_rs2;
            r_fwd_hit  <= wr_hits(bus.req_rs1, bus.wr_en, bus.wr_addr);
            r_fwd_data <= bus.wr_data;
          end
        end
        RD2: begin
          r_op1      <= fwd_operand(r_rs1, r_fwd_hit ? r_fwd_data : w_rd_data,
                                    bus.wr_en, bus.wr_addr, bus.wr_data);
          r_fwd_hit  <= wr_hits(r_rs2, bus.wr_en, bus.wr_addr);
          r_fwd_data <= bus.wr_data;
        end
        CAP2: begin
          r_rsp1      <= fwd_operand(r_rs1, r_op1,
                                     bus.wr_en, bus.wr_addr, bus.wr_data);
          r_rsp2      <= fwd_operand(r_rs2, r_fwd_hit ? r_fwd_data : w_rd_data,
                                     bus.wr_en, bus.wr_addr, bus.wr_data);
          r_rsp_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready    = (r_state == IDLE);
  assign bus.busy         = (r_state != IDLE);
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rs1_data = r_rsp1;
  assign bus.rsp_rs2_data = r_rsp2;

  armleocpu_regfile_one_lane #(
    .ELEMENTS_W (ELEMENTS_W),
    .WIDTH      (WIDTH)
  ) u_lane (
    .clk     (clk),
    .rd_en   (w_rd_en),
    .rd_addr (w_rd_addr),
    .rd_data (w_rd_data),
    .wr_en   (w_lane_we),
    .wr_addr (w_lane_waddr),
    .wr_data (w_lane_wdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_armleocpu_regfile_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_armleocpu_regfile_ctrl
// Purpose  : Self-checking bench for armleocpu_regfile_ctrl. A register
//            array model gives operand values: each operand equals the
//            register contents after all writes up to and including the
//            cycle two after accept.
// Revision : 1.0 - initial release
// ============================================================================
module tb_armleocpu_regfile_ctrl;

  logic clk;
  logic rst;

  armleocpu_regfile_ctrl_if #(.ELEMENTS_W(5), .WIDTH(32)) bus ();

  armleocpu_regfile_ctrl #(.ELEMENTS_W(5), .WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [4:0] a;
    logic [4:0] b;
  } pend_t;

  int          total;
  int          bad;
  int          cyc;
  int          last_acc;
  int          clear_left;
  logic [31:0] model [32];
  pend_t       pq [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  // One clock cycle: check outputs, present inputs, advance model, clock.
  task automatic drive_cycle(input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                             input logic rv, input logic [4:0] a, input logic [4:0] b);
    logic exp_ready;
    logic exp_rsp;
    exp_ready = (clear_left == 0) && (cyc != last_acc + 1) && (cyc != last_acc + 2);
    exp_rsp   = (pq.size() != 0) && (pq[0].due == cyc);
    check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    check("busy", 32'(bus.busy), 32'(!exp_ready));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rsp));
    if (exp_rsp) begin
      check("rsp_rs1_data", bus.rsp_rs1_data, rd_model(pq[0].a));
      check("rsp_rs2_data", bus.rsp_rs2_data, rd_model(pq[0].b));
      void'(pq.pop_front());
    end
    bus.wr_en     = wen;
    bus.wr_addr   = wa;
    bus.wr_data   = wd;
    bus.req_valid = rv;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    if (rv && exp_ready) begin
      pq.push_back('{due: cyc + 3, a: a, b: b});
      last_acc = cyc;
    end
    if (wen && wa != 5'd0) model[wa] = wd;
    if (clear_left > 0) clear_left--;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    logic exp_ready_rst;
`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
    exp_ready_rst = 1'b0;
`else
    exp_ready_rst = 1'b1;
`endif
    bus.req_valid = 1'b0;
    bus.wr_en     = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rs1_data", bus.rsp_rs1_data, 32'd0);
    check("rst_rs2_data", bus.rsp_rs2_data, 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'(exp_ready_rst));
    check("rst_busy", 32'(bus.busy), 32'(!exp_ready_rst));
    pq.delete();
    last_acc = -100;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
    clear_left = 32;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
`else
    clear_left = 0;
`endif
  endtask

  initial begin
    int n;
    total = 0; bad = 0; cyc = 0; last_acc = -100; clear_left = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    bus.req_valid = 1'b0; bus.req_rs1 = '0; bus.req_rs2 = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    rst = 1'b0;

    do_reset();
    n = clear_left;
    repeat (n) idle();

`ifdef ARMLEOCPU_REGFILE_CLEAR_EN
    // Cleared lane reads back zero.
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 5'd1);
    repeat (3) idle();
    check("t6_rs1", bus.rsp_rs1_data, 32'd0);
    check("t6_rs2", bus.rsp_rs2_data, 32'd0);
`endif

    // Basic two-operand read.
    drive_cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
    drive_cycle(1'b1, 5'd6, 32'h12345678, 1'b0, 5'd0, 5'd0);
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd6);
    repeat (3) idle();
    check("t1_rs1", bus.rsp_rs1_data, 32'hDEADBEEF);
    check("t1_rs2", bus.rsp_rs2_data, 32'h12345678);

    // x0 stays zero even after a write.
    drive_cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd0);
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
    repeat (3) idle();
    check("t2_rs1", bus.rsp_rs1_data, 32'd0);
    check("t2_rs2", bus.rsp_rs2_data, 32'd0);

    // Forwarding of writes at accept and at the capture cycle.
    drive_cycle(1'b1, 5'd7, 32'h1, 1'b0, 5'd0, 5'd0);
    drive_cycle(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 5'd7);
    idle();
    drive_cycle(1'b1, 5'd7, 32'hB, 1'b0, 5'd0, 5'd0);
    idle();
    check("t3_rs1", bus.rsp_rs1_data, 32'hB);
    check("t3_rs2", bus.rsp_rs2_data, 32'hB);

    // Back-to-back requests with req_valid held high.
    repeat (7) drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd7);
    repeat (3) idle();
    check("t4_drain", 32'(pq.size()), 32'd0);

    // Reset during RD2 drops the request.
    drive_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd6);
    do_reset();
    repeat (4) idle();
    check("t5_rs1", bus.rsp_rs1_data, 32'd0);
    check("t5_rs2", bus.rsp_rs2_data, 32'd0);
    n = clear_left;
    repeat (n) idle();

    // Give every register a known value.
    for (int i = 1; i < 32; i++) drive_cycle(1'b1, 5'(i), 32'h100 + 32'(i), 1'b0, 5'd0, 5'd0);

    // Random mixed traffic concentrated on a few registers for collisions.
    for (int i = 0; i < 400; i++) begin
      drive_cycle(($urandom_range(0, 2) != 0),
                  5'($urandom_range(0, 7)),
                  32'($urandom),
                  ($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
    end
    repeat (4) idle();
    check("rand_drain", 32'(pq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
